// File: rtl/pci_ahb_pkg.sv
// Shared encodings for the PCI-target to AHB-master bridge.
package pci_ahb_pkg;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [31:0] ERR_RDATA     = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_DRAIN,
        ST_REL
    } bridge_state_t;

endpackage

// File: rtl/pci_ahb_win_decode.sv
// PCI window hit / word-alignment check and PCI-to-AHB address translation.
module pci_ahb_win_decode #(
    parameter logic [31:0] WIN_BASE = 32'h4000_0000,
    parameter logic [31:0] WIN_MASK = 32'hFFFF_0000,
    parameter logic [31:0] AHB_BASE = 32'h2000_0000
) (
    input  logic [31:0] pci_addr,
    output logic        hit,
    output logic        aligned,
    output logic [31:0] ahb_addr
);

    // Pure bit masking: offsets never carry into the AHB base bits.
    assign hit      = ((pci_addr & WIN_MASK) == WIN_BASE);
    assign aligned  = (pci_addr[1:0] == 2'b00);
    assign ahb_addr = AHB_BASE | (pci_addr & ~WIN_MASK);

endmodule

// File: rtl/pci_to_ahb_bridge.sv
// Accepts single-word PCI target requests and issues one AHB NONSEQ word
// transfer per request, answering the initiator with a one-cycle ready pulse.
module pci_to_ahb_bridge
    import pci_ahb_pkg::*;
#(
    parameter logic [31:0] WIN_BASE = 32'h4000_0000,
    parameter logic [31:0] WIN_MASK = 32'hFFFF_0000,
    parameter logic [31:0] AHB_BASE = 32'h2000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        PCI_REQ,
    input  logic        PCI_WR,
    input  logic [31:0] PCI_ADDR,
    input  logic [31:0] PCI_WDATA,
    output logic        PCI_GNT,
    output logic        PCI_READY,
    output logic [31:0] PCI_RDATA,
    output logic        PCI_ERR,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    bridge_state_t    state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [31:0]      wdata_q;
    logic             err_seen;
    logic             win_hit;
    logic             win_aligned;
    logic [31:0]      win_haddr;

    pci_ahb_win_decode #(
        .WIN_BASE (WIN_BASE),
        .WIN_MASK (WIN_MASK),
        .AHB_BASE (AHB_BASE)
    ) u_win_decode (
        .pci_addr (PCI_ADDR),
        .hit      (win_hit),
        .aligned  (win_aligned),
        .ahb_addr (win_haddr)
    );

    assign HSIZE    = HSIZE_WORD;
    assign cnt_next = wait_cnt + CNT_W'(1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            PCI_GNT   <= 1'b0;
            PCI_READY <= 1'b0;
            PCI_ERR   <= 1'b0;
            PCI_RDATA <= '0;
            HADDR     <= '0;
            HTRANS    <= HTRANS_IDLE;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
            wdata_q   <= '0;
            wait_cnt  <= '0;
            err_seen  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (PCI_REQ) begin
                        PCI_GNT <= 1'b1;
                        if (win_hit && win_aligned) begin
                            state   <= ST_ADDR;
                            HTRANS  <= HTRANS_NONSEQ;
                            HADDR   <= win_haddr;
                            HWRITE  <= PCI_WR;
                            wdata_q <= PCI_WDATA;
                        end else begin
                            state     <= ST_RESP;
                            PCI_READY <= 1'b1;
                            PCI_ERR   <= 1'b1;
                            PCI_RDATA <= ERR_RDATA;
                        end
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        state    <= ST_DATA;
                        HTRANS   <= HTRANS_IDLE;
                        HWDATA   <= wdata_q;
                        wait_cnt <= '0;
                        err_seen <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (HREADY) begin
                        PCI_RDATA <= HWRITE ? 32'h0 : HRDATA;
                        PCI_ERR   <= HRESP | err_seen;
                        PCI_READY <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= cnt_next;
                        if (HRESP) begin
                            err_seen <= 1'b1;
                        end
                        // Give up on the slave but keep tracking its data phase in DRAIN.
                        if (cnt_next == CNT_W'(TIMEOUT)) begin
                            PCI_READY <= 1'b1;
                            PCI_ERR   <= 1'b1;
                            PCI_RDATA <= ERR_RDATA;
                            state     <= ST_DRAIN;
                        end
                    end
                end
                ST_RESP: begin
                    PCI_READY <= 1'b0;
                    PCI_GNT   <= 1'b0;
                    state     <= ST_REL;
                end
                ST_DRAIN: begin
                    PCI_READY <= 1'b0;
                    PCI_GNT   <= 1'b0;
                    if (HREADY) begin
                        state <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!PCI_REQ) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pci_to_ahb_bridge.sv
// Self-checking bench: directed and randomized PCI requests against a
// transaction-level model of window decode, latency and completion status.
module tb_pci_to_ahb_bridge;

    localparam logic [31:0] WIN_BASE = 32'h4000_0000;
    localparam logic [31:0] WIN_SPAN = 32'h0001_0000;
    localparam logic [31:0] AHB_BASE = 32'h2000_0000;
    localparam int          TIMEOUT  = 16;

    logic        HCLK;
    logic        HRESETn;
    logic        PCI_REQ;
    logic        PCI_WR;
    logic [31:0] PCI_ADDR;
    logic [31:0] PCI_WDATA;
    logic        PCI_GNT;
    logic        PCI_READY;
    logic [31:0] PCI_RDATA;
    logic        PCI_ERR;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int checks = 0;
    int errors = 0;

    pci_to_ahb_bridge #(
        .WIN_BASE (WIN_BASE),
        .WIN_MASK (32'hFFFF_0000),
        .AHB_BASE (AHB_BASE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .PCI_REQ   (PCI_REQ),
        .PCI_WR    (PCI_WR),
        .PCI_ADDR  (PCI_ADDR),
        .PCI_WDATA (PCI_WDATA),
        .PCI_GNT   (PCI_GNT),
        .PCI_READY (PCI_READY),
        .PCI_RDATA (PCI_RDATA),
        .PCI_ERR   (PCI_ERR),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One PCI request with an AHB slave that stalls aw address-phase cycles
    // and dw data-phase cycles; edge 0 is the edge that samples PCI_REQ.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int aw, input int dw,
                                 input bit resp_early, input bit resp_last, input int hold);
        bit          accept, tout, exp_err, got_err;
        int          ready_e, data_end, last_e, ready_at, ready_cnt, nonseq_cnt;
        logic [31:0] exp_haddr, exp_rdata, got_rdata;
        logic [1:0]  prev_htrans;

        accept    = (addr >= WIN_BASE) && (addr < WIN_BASE + WIN_SPAN) && (addr % 4 == 0);
        exp_haddr = AHB_BASE + (addr - WIN_BASE);
        tout      = accept && (dw >= TIMEOUT);
        data_end  = accept ? aw + 2 + dw : 0;
        ready_e   = !accept ? 0 : (tout ? aw + 1 + TIMEOUT : aw + 2 + dw);
        exp_err   = !accept || tout || (resp_early && dw > 0) || resp_last;
        exp_rdata = (!accept || tout) ? 32'hFFFF_FFFF : (wr ? 32'h0 : rdata);
        last_e    = ((ready_e + hold + 1 > data_end) ? ready_e + hold + 1 : data_end) + 3;

        ready_at    = -1;
        ready_cnt   = 0;
        nonseq_cnt  = 0;
        got_err     = 1'b0;
        got_rdata   = '0;
        prev_htrans = HTRANS;
        PCI_WR      = wr;
        PCI_ADDR    = addr;
        PCI_WDATA   = wdata;

        for (int e = 0; e <= last_e; e++) begin
            PCI_REQ = (e <= ready_e + hold);
            HREADY  = 1'b1;
            HRESP   = 1'b0;
            HRDATA  = $urandom;
            if (accept) begin
                if (e >= 1 && e <= aw) begin
                    HREADY = 1'b0;
                end else if (e >= aw + 2 && e <= aw + 1 + dw) begin
                    HREADY = 1'b0;
                    HRESP  = resp_early;
                end else if (e == data_end) begin
                    HRESP  = resp_last;
                    HRDATA = rdata;
                end
            end
            @(posedge HCLK);
            #1;
            if (HTRANS == 2'b10 && prev_htrans != 2'b10) nonseq_cnt++;
            prev_htrans = HTRANS;
            if (PCI_READY) begin
                if (ready_cnt == 0) begin
                    ready_at  = e;
                    got_err   = PCI_ERR;
                    got_rdata = PCI_RDATA;
                end
                ready_cnt++;
            end
            if (e == 0) begin
                checkOutput("gnt_on_accept", PCI_GNT, 1);
                if (accept) begin
                    checkOutput("haddr", HADDR, exp_haddr);
                    checkOutput("hwrite", HWRITE, wr);
                    checkOutput("htrans_nonseq", HTRANS, 2'b10);
                    checkOutput("hsize", HSIZE, 3'b010);
                end else begin
                    checkOutput("htrans_reject", HTRANS, 2'b00);
                end
            end
            if (accept && e == aw + 1) begin
                checkOutput("htrans_data_phase", HTRANS, 2'b00);
                if (wr) checkOutput("hwdata", HWDATA, wdata);
            end
            @(negedge HCLK);
        end

        checkOutput("ready_cycle", ready_at, ready_e);
        checkOutput("ready_pulses", ready_cnt, 1);
        checkOutput("pci_err", got_err, exp_err);
        checkOutput("pci_rdata", got_rdata, exp_rdata);
        checkOutput("nonseq_count", nonseq_cnt, accept ? 1 : 0);
        checkOutput("gnt_released", PCI_GNT, 0);
        checkOutput("htrans_idle_end", HTRANS, 2'b00);
    endtask

    // Assert reset while stalled in the address phase (in_data=0) or data phase.
    task automatic resetMidTransfer(input bit in_data);
        PCI_REQ  = 1'b1;
        PCI_WR   = 1'b0;
        PCI_ADDR = WIN_BASE + 32'h100;
        HREADY   = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        HREADY = in_data;
        @(posedge HCLK);
        @(negedge HCLK);
        HREADY = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        checkOutput(in_data ? "rst_data_htrans" : "rst_addr_htrans", HTRANS, 2'b00);
        checkOutput(in_data ? "rst_data_gnt" : "rst_addr_gnt", PCI_GNT, 0);
        checkOutput("rst_ready", PCI_READY, 0);
        PCI_REQ = 1'b0;
        HREADY  = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
    endtask

    initial begin
        bit          wr;
        logic [31:0] addr;
        int          r, dw;

        HRESETn   = 1'b0;
        PCI_REQ   = 1'b0;
        PCI_WR    = 1'b0;
        PCI_ADDR  = '0;
        PCI_WDATA = '0;
        HRDATA    = '0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        repeat (3) @(negedge HCLK);
        checkOutput("reset_gnt", PCI_GNT, 0);
        checkOutput("reset_ready", PCI_READY, 0);
        checkOutput("reset_err", PCI_ERR, 0);
        checkOutput("reset_rdata", PCI_RDATA, 0);
        checkOutput("reset_haddr", HADDR, 0);
        checkOutput("reset_htrans", HTRANS, 0);
        checkOutput("reset_hwrite", HWRITE, 0);
        checkOutput("reset_hwdata", HWDATA, 0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        applyStimulus(1, 32'h4000_0010, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 0, 0);
        applyStimulus(0, 32'h4000_0020, 32'h0, 32'h1234_5678, 0, 2, 0, 0, 0);
        applyStimulus(0, 32'h5000_0000, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h4000_0002, 32'h1111_2222, 32'h0, 0, 0, 0, 0, 1);
        applyStimulus(0, 32'h4000_FFFC, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 0, 0);
        applyStimulus(0, 32'h4000_0000, 32'h0, 32'h0BAD_CAFE, 1, 0, 0, 0, 0);
        applyStimulus(0, 32'h3FFF_FFFC, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        applyStimulus(0, 32'h4001_0000, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        applyStimulus(0, 32'h4000_0040, 32'h0, 32'hAAAA_5555, 0, 1, 1, 1, 0);
        applyStimulus(1, 32'h4000_0044, 32'h0F0F_0F0F, 32'h0, 0, 3, 1, 0, 0);
        applyStimulus(0, 32'h4000_0048, 32'h0, 32'h5A5A_A5A5, 0, 2, 0, 1, 0);
        applyStimulus(0, 32'h4000_0080, 32'h0, 32'h7777_8888, 0, 20, 0, 0, 1);
        applyStimulus(0, 32'h4000_0084, 32'h0, 32'h1357_9BDF, 0, TIMEOUT - 1, 0, 0, 0);
        applyStimulus(1, 32'h4000_0088, 32'h2468_ACE0, 32'h0, 2, TIMEOUT, 0, 0, 0);
        applyStimulus(1, 32'h4000_00C0, 32'hFEED_FACE, 32'h0, 2, 1, 0, 0, 4);

        resetMidTransfer(1'b0);
        resetMidTransfer(1'b1);
        applyStimulus(1, 32'h4000_0100, 32'hC0DE_0001, 32'h0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       addr = WIN_BASE + $urandom_range(0, 16383) * 4;
            else if (r == 7) addr = WIN_BASE + $urandom_range(0, 16383) * 4 + $urandom_range(1, 3);
            else             addr = $urandom;
            wr = $urandom_range(0, 1);
            dw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
            applyStimulus(wr, addr, $urandom, $urandom, $urandom_range(0, 2), dw,
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                          $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
